// File: rtl/kbd_pkg.sv
// Shared constants for the PS/2 keyboard-to-memory ring writer:
// default memory map, PS/2 frame layout and memory FSM encoding.
package kbd_pkg;

    localparam logic [31:0] DEF_BUF_BASE    = 32'h0000_1000;
    localparam int          DEF_BUF_WORDS   = 16;
    localparam logic [31:0] DEF_HEAD_ADDR   = 32'h0000_0FF8;
    localparam logic [31:0] DEF_TAIL_ADDR   = 32'h0000_0FFC;
    localparam int          DEF_READ_LAT    = 2;
    localparam int          DEF_TIMEOUT_CYC = 50000;

    localparam int   FRAME_BITS = 11;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_TAIL,
        ST_CHECK,
        ST_WR_DATA,
        ST_WR_HEAD
    } mem_state_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receiver: synchronises the raw lines, shifts in 11-bit frames on
// falling clock edges and reports either a one-cycle code strobe or an error pulse.
module ps2_rx
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          clk_s1, clk_s2, clk_prev;
    logic          data_s1, data_s2;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [TW-1:0] idle_cnt;
    logic          fall;
    logic [10:0]   frame;
    logic          good;

    assign fall  = clk_prev & ~clk_s2;
    // The final bit is still on the line, so the full frame is assembled here.
    assign frame = {data_s2, shreg};
    assign good  = (frame[0] == START_BIT) && (frame[10] == STOP_BIT) && (^frame[9:1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            clk_prev   <= 1'b1;
            data_s1    <= 1'b1;
            data_s2    <= 1'b1;
            bit_cnt    <= '0;
            shreg      <= '0;
            idle_cnt   <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            clk_s1     <= ps2_clk;
            clk_s2     <= clk_s1;
            clk_prev   <= clk_s2;
            data_s1    <= ps2_data;
            data_s2    <= data_s1;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                    bit_cnt <= '0;
                    if (good) begin
                        code       <= frame[8:1];
                        code_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    shreg   <= {data_s2, shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != '0) begin
                // A stalled frame is abandoned so the next start bit realigns us.
                if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    bit_cnt   <= '0;
                    idle_cnt  <= '0;
                    frame_err <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/kbd_mem_writer.sv
// Keyboard ring writer: buffers one received scancode and pushes it into a
// memory ring shared with the CPU, publishing the new head after each entry.
module kbd_mem_writer
    import kbd_pkg::*;
#(
    parameter logic [31:0] BUF_BASE    = DEF_BUF_BASE,
    parameter int          BUF_WORDS   = DEF_BUF_WORDS,
    parameter logic [31:0] HEAD_ADDR   = DEF_HEAD_ADDR,
    parameter logic [31:0] TAIL_ADDR   = DEF_TAIL_ADDR,
    parameter int          READ_LAT    = DEF_READ_LAT,
    parameter int          TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] io_addr,
    output logic        io_wren,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata,
    output logic        overflow,
    output logic        frame_err,
    output logic        busy
);

    localparam int IW = $clog2(BUF_WORDS);
    localparam int RW = $clog2(READ_LAT + 1);

    mem_state_t    state, state_nxt;
    logic [IW-1:0] head, tail, head_inc;
    logic          pend_valid;
    logic [7:0]    pend_code;
    logic [RW-1:0] rd_cnt;
    logic          rd_done, full, free;
    logic [31:0]   addr_q, wdata_q;
    logic [7:0]    rx_code;
    logic          rx_valid, rx_err;
    logic          rdata_unused;

    ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code       (rx_code),
        .code_valid (rx_valid),
        .frame_err  (rx_err)
    );

    assign head_inc     = head + 1'b1;
    assign full         = (head_inc == tail);
    assign rd_done      = (rd_cnt == RW'(READ_LAT - 1));
    assign free         = ((state == ST_CHECK) && full) || (state == ST_WR_HEAD);
    assign busy         = (state != ST_IDLE);
    assign rdata_unused = ^io_rdata[31:IW];

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (pend_valid) state_nxt = ST_RD_TAIL;
            ST_RD_TAIL: if (rd_done) state_nxt = ST_CHECK;
            ST_CHECK:   state_nxt = full ? ST_IDLE : ST_WR_DATA;
            ST_WR_DATA: state_nxt = ST_WR_HEAD;
            ST_WR_HEAD: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Bus values persist through addr_q/wdata_q when no state drives them.
    always_comb begin
        io_addr  = addr_q;
        io_wdata = wdata_q;
        io_wren  = 1'b0;
        case (state)
            ST_RD_TAIL: io_addr = TAIL_ADDR;
            ST_WR_DATA: begin
                io_addr  = BUF_BASE + 32'({head, 2'b00});
                io_wren  = 1'b1;
                io_wdata = {24'b0, pend_code};
            end
            ST_WR_HEAD: begin
                io_addr  = HEAD_ADDR;
                io_wren  = 1'b1;
                io_wdata = 32'(head_inc);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            pend_valid <= 1'b0;
            pend_code  <= '0;
            rd_cnt     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            addr_q  <= io_addr;
            wdata_q <= io_wdata;
            rd_cnt  <= ((state == ST_RD_TAIL) && !rd_done) ? rd_cnt + 1'b1 : '0;
            if ((state == ST_RD_TAIL) && rd_done) tail <= io_rdata[IW-1:0];
            if (state == ST_WR_HEAD) head <= head_inc;
            if (rx_err) frame_err <= 1'b1;
            if ((state == ST_CHECK) && full) overflow <= 1'b1;
            // A code arriving as the slot frees takes the slot rather than being lost.
            if (rx_valid) begin
                if (pend_valid && !free) begin
                    overflow <= 1'b1;
                end else begin
                    pend_valid <= 1'b1;
                    pend_code  <= rx_code;
                end
            end else if (free) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kbd_mem_writer.sv
// Self-checking bench for kbd_mem_writer: PS/2 frames in, memory writes
// logged and compared against a ring-buffer reference model.
module tb_kbd_mem_writer;
    import kbd_pkg::*;

    localparam int TMO       = 300;
    localparam int BUF_WORDS = DEF_BUF_WORDS;

    logic        clk = 1'b0;
    logic        rst, ps2_clk, ps2_data;
    logic [31:0] io_addr, io_wdata, io_rdata;
    logic        io_wren, overflow, frame_err, busy;
    logic [31:0] tail_word;
    logic [31:0] rd_q;

    int total = 0;
    int bad   = 0;

    logic [63:0] wr_log[$];
    logic [63:0] exp_log[$];
    int          head_m;
    bit          ovf_m, ferr_m;

    kbd_mem_writer #(.TIMEOUT_CYC(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .io_addr   (io_addr),
        .io_wren   (io_wren),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .overflow  (overflow),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // CPU-side memory: only the tail word is meaningful, anything else reads as ones.
    always @(posedge clk) rd_q <= (io_addr == DEF_TAIL_ADDR) ? tail_word : 32'hFFFF_FFFF;
    assign io_rdata = rd_q;

    always @(negedge clk) if (io_wren === 1'b1) wr_log.push_back({io_addr, io_wdata});

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void model_frame(input logic [7:0] c, input bit is_bad);
        if (is_bad) begin
            ferr_m = 1'b1;
        end else if (((head_m + 1) % BUF_WORDS) == int'(tail_word % BUF_WORDS)) begin
            ovf_m = 1'b1;
        end else begin
            exp_log.push_back({DEF_BUF_BASE + 32'(4 * head_m), 32'(c)});
            head_m = (head_m + 1) % BUF_WORDS;
            exp_log.push_back({DEF_HEAD_ADDR, 32'(head_m)});
        end
    endfunction

    task automatic do_reset();
        wr_log.delete();
        exp_log.delete();
        head_m   = 0;
        ovf_m    = 1'b0;
        ferr_m   = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input bit bad_par, input int nbits);
        logic [10:0] b;
        b = {1'b1, (~^c) ^ bad_par, c, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = b[i];
            repeat (3) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (4) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (2) @(negedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total += 7;
        if (io_addr !== 32'h0) begin bad++; $display("[TB] FAIL rst_addr got=%h exp=0", io_addr); end
        if (io_wren !== 1'b0) begin bad++; $display("[TB] FAIL rst_wren got=%b exp=0", io_wren); end
        if (io_wdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_wdata got=%h exp=0", io_wdata); end
        if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL rst_ovf got=%b exp=0", overflow); end
        if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_ferr got=%b exp=0", frame_err); end
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%b exp=0", busy); end
        if (wr_log.size() != 0) begin bad++; $display("[TB] FAIL rst_writes got=%0d exp=0", wr_log.size()); end
    endtask

    task automatic test_single();
        do_reset();
        tail_word = 32'h0;
        model_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0, 11);
        repeat (20) @(negedge clk);
        total++;
        if (wr_log.size() != exp_log.size()) begin bad++; $display("[TB] FAIL single_count got=%0d exp=%0d", wr_log.size(), exp_log.size()); end
        for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++) begin
            total++;
            if (wr_log[i] !== exp_log[i]) begin bad++; $display("[TB] FAIL single_wr%0d got=%h exp=%h", i, wr_log[i], exp_log[i]); end
        end
        total += 2;
        if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL single_ovf got=%b exp=0", overflow); end
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy got=%b exp=0", busy); end
    endtask

    task automatic test_bad_parity();
        do_reset();
        tail_word = 32'h0;
        model_frame(8'h1C, 1'b1);
        send_frame(8'h1C, 1'b1, 11);
        repeat (20) @(negedge clk);
        total += 3;
        if (wr_log.size() != 0) begin bad++; $display("[TB] FAIL parity_writes got=%0d exp=0", wr_log.size()); end
        if (frame_err !== ferr_m) begin bad++; $display("[TB] FAIL parity_ferr got=%b exp=%b", frame_err, ferr_m); end
        if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL parity_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_fill();
        logic [7:0] c;
        do_reset();
        tail_word = 32'h0;
        for (int n = 0; n < 15; n++) begin
            c = 8'($urandom);
            model_frame(c, 1'b0);
            send_frame(c, 1'b0, 11);
            repeat (20) @(negedge clk);
        end
        total += 2;
        if (wr_log.size() != exp_log.size()) begin bad++; $display("[TB] FAIL fill_count got=%0d exp=%0d", wr_log.size(), exp_log.size()); end
        if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL fill_ovf_early got=%b exp=0", overflow); end
        for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++) begin
            total++;
            if (wr_log[i] !== exp_log[i]) begin bad++; $display("[TB] FAIL fill_wr%0d got=%h exp=%h", i, wr_log[i], exp_log[i]); end
        end
        wr_log.delete();
        exp_log.delete();
        c = 8'($urandom);
        model_frame(c, 1'b0);
        send_frame(c, 1'b0, 11);
        repeat (20) @(negedge clk);
        total += 3;
        if (wr_log.size() != 0) begin bad++; $display("[TB] FAIL full_writes got=%0d exp=0", wr_log.size()); end
        if (overflow !== ovf_m) begin bad++; $display("[TB] FAIL full_ovf got=%b exp=%b", overflow, ovf_m); end
        if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL full_ferr got=%b exp=0", frame_err); end
    endtask

    task automatic test_wrap();
        logic [7:0] c;
        do_reset();
        for (int n = 0; n < 15; n++) begin
            tail_word = 32'(head_m);
            c = 8'($urandom);
            model_frame(c, 1'b0);
            send_frame(c, 1'b0, 11);
            repeat (20) @(negedge clk);
        end
        wr_log.delete();
        exp_log.delete();
        tail_word = 32'h1234_56F3;
        c = 8'($urandom);
        model_frame(c, 1'b0);
        send_frame(c, 1'b0, 11);
        repeat (20) @(negedge clk);
        total++;
        if (wr_log.size() != 2) begin
            bad++;
            $display("[TB] FAIL wrap_count got=%0d exp=2", wr_log.size());
        end else begin
            total += 4;
            if (wr_log[0] !== exp_log[0]) begin bad++; $display("[TB] FAIL wrap_data got=%h exp=%h", wr_log[0], exp_log[0]); end
            if (wr_log[1] !== exp_log[1]) begin bad++; $display("[TB] FAIL wrap_head got=%h exp=%h", wr_log[1], exp_log[1]); end
            if (wr_log[0][63:32] !== 32'h103C) begin bad++; $display("[TB] FAIL wrap_addr got=%h exp=103c", wr_log[0][63:32]); end
            if (wr_log[1][31:0] !== 32'h0) begin bad++; $display("[TB] FAIL wrap_zero got=%h exp=0", wr_log[1][31:0]); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        tail_word = 32'h0;
        send_frame(8'hA5, 1'b0, 5);
        repeat (TMO + 50) @(negedge clk);
        ferr_m = 1'b1;
        model_frame(8'h5A, 1'b0);
        send_frame(8'h5A, 1'b0, 11);
        repeat (20) @(negedge clk);
        total += 2;
        if (frame_err !== ferr_m) begin bad++; $display("[TB] FAIL tmo_ferr got=%b exp=%b", frame_err, ferr_m); end
        if (wr_log.size() != exp_log.size()) begin bad++; $display("[TB] FAIL tmo_count got=%0d exp=%0d", wr_log.size(), exp_log.size()); end
        for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++) begin
            total++;
            if (wr_log[i] !== exp_log[i]) begin bad++; $display("[TB] FAIL tmo_wr%0d got=%h exp=%h", i, wr_log[i], exp_log[i]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] c;
        bit         b;
        do_reset();
        for (int n = 0; n < 12; n++) begin
            tail_word = $urandom;
            c = 8'($urandom);
            b = ($urandom_range(0, 3) == 0);
            model_frame(c, b);
            send_frame(c, b, 11);
            repeat (20) @(negedge clk);
        end
        total += 3;
        if (wr_log.size() != exp_log.size()) begin bad++; $display("[TB] FAIL rand_count got=%0d exp=%0d", wr_log.size(), exp_log.size()); end
        if (overflow !== ovf_m) begin bad++; $display("[TB] FAIL rand_ovf got=%b exp=%b", overflow, ovf_m); end
        if (frame_err !== ferr_m) begin bad++; $display("[TB] FAIL rand_ferr got=%b exp=%b", frame_err, ferr_m); end
        for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++) begin
            total++;
            if (wr_log[i] !== exp_log[i]) begin bad++; $display("[TB] FAIL rand_wr%0d got=%h exp=%h", i, wr_log[i], exp_log[i]); end
        end
    endtask

    task automatic test_rst_mid_write();
        bit hit;
        int heads;
        do_reset();
        tail_word = 32'h0;
        send_frame(8'h77, 1'b0, 11);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (io_wren === 1'b1 && io_addr !== DEF_HEAD_ADDR) hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("[TB] FAIL midrst_wait got=no_data_write exp=data_write");
        end else begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            total += 6;
            if (io_wren !== 1'b0) begin bad++; $display("[TB] FAIL midrst_wren got=%b exp=0", io_wren); end
            if (io_addr !== 32'h0) begin bad++; $display("[TB] FAIL midrst_addr got=%h exp=0", io_addr); end
            if (io_wdata !== 32'h0) begin bad++; $display("[TB] FAIL midrst_wdata got=%h exp=0", io_wdata); end
            if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got=%b exp=0", busy); end
            if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ovf got=%b exp=0", overflow); end
            if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ferr got=%b exp=0", frame_err); end
            repeat (20) @(negedge clk);
            heads = 0;
            foreach (wr_log[i]) if (wr_log[i][63:32] == DEF_HEAD_ADDR) heads++;
            total++;
            if (heads != 0) begin bad++; $display("[TB] FAIL midrst_headwr got=%0d exp=0", heads); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        tail_word = 32'h0;
        $display("[TB] starting kbd_mem_writer bench");
        test_reset();
        test_single();
        test_bad_parity();
        test_fill();
        test_wrap();
        test_timeout();
        test_random();
        test_rst_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
